// File: rtl/csr_access_ctrl_if.sv
// Bundles the core, debug and CSR-file signals of csr_access_ctrl.
// slave is the controller's view; master is the view of the surrounding logic.
interface csr_access_ctrl_if #(
    parameter int unsigned CSR_ADDR     = 12,
    parameter int unsigned CSR_OP_WIDTH = 3,
    parameter int unsigned XLEN         = 32
);
    logic                    core_req_i;
    logic [CSR_ADDR-1:0]     core_addr_i;
    logic [CSR_OP_WIDTH-1:0] core_op_i;
    logic [XLEN-1:0]         core_wdata_i;
    logic [4:0]              core_zimm_i;
    logic                    core_rs1_x0_i;
    logic                    core_ack_o;
    logic [XLEN-1:0]         core_rdata_o;
    logic                    core_illegal_o;

    logic                    dbg_req_i;
    logic [CSR_ADDR-1:0]     dbg_addr_i;
    logic                    dbg_we_i;
    logic [XLEN-1:0]         dbg_wdata_i;
    logic                    dbg_ack_o;
    logic [XLEN-1:0]         dbg_rdata_o;
    logic                    dbg_err_o;

    logic [CSR_ADDR-1:0]     csr_addr_o;
    logic                    csr_re_o;
    logic [XLEN-1:0]         csr_rdata_i;
    logic                    csr_illegal_i;
    logic                    csr_we_o;
    logic [XLEN-1:0]         csr_wdata_o;
    logic                    busy_o;

    modport slave (
        input  core_req_i, core_addr_i, core_op_i, core_wdata_i, core_zimm_i, core_rs1_x0_i,
        output core_ack_o, core_rdata_o, core_illegal_o,
        input  dbg_req_i, dbg_addr_i, dbg_we_i, dbg_wdata_i,
        output dbg_ack_o, dbg_rdata_o, dbg_err_o,
        output csr_addr_o, csr_re_o, csr_we_o, csr_wdata_o, busy_o,
        input  csr_rdata_i, csr_illegal_i
    );

    modport master (
        output core_req_i, core_addr_i, core_op_i, core_wdata_i, core_zimm_i, core_rs1_x0_i,
        input  core_ack_o, core_rdata_o, core_illegal_o,
        output dbg_req_i, dbg_addr_i, dbg_we_i, dbg_wdata_i,
        input  dbg_ack_o, dbg_rdata_o, dbg_err_o,
        input  csr_addr_o, csr_re_o, csr_we_o, csr_wdata_o, busy_o,
        output csr_rdata_i, csr_illegal_i
    );
endinterface

// File: rtl/csr_access_ctrl.sv
// CSR access sequencer: arbitrates core/debug requests and runs an atomic
// read-modify-write against the CSR file, returning the old value.
module csr_access_ctrl #(
    parameter int unsigned CSR_ADDR     = 12,
    parameter int unsigned CSR_OP_WIDTH = 3,
    parameter int unsigned XLEN         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    csr_access_ctrl_if.slave bus
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_CALC, S_WRITE, S_RESP} state_e;
    typedef enum logic [1:0] {K_RW, K_RS, K_RC} kind_e;

    state_e              state_q, state_d;
    kind_e               kind_q, kind_d;
    logic                last_dbg_q, last_dbg_d;
    logic                src_dbg_q, src_dbg_d;
    logic                wreq_q, wreq_d;
    logic                illegal_q, illegal_d;
    logic [CSR_ADDR-1:0] addr_q, addr_d;
    logic [XLEN-1:0]     src_q, src_d;
    logic [XLEN-1:0]     old_q, old_d;

    logic                core_ack_q, core_ack_d;
    logic [XLEN-1:0]     core_rdata_q, core_rdata_d;
    logic                core_illegal_q, core_illegal_d;
    logic                dbg_ack_q, dbg_ack_d;
    logic [XLEN-1:0]     dbg_rdata_q, dbg_rdata_d;
    logic                dbg_err_q, dbg_err_d;
    logic [CSR_ADDR-1:0] csr_addr_q, csr_addr_d;
    logic                csr_re_q, csr_re_d;
    logic                csr_we_q, csr_we_d;
    logic [XLEN-1:0]     csr_wdata_q, csr_wdata_d;
    logic                busy_q, busy_d;

    kind_e               core_kind;
    logic [XLEN-1:0]     core_src;
    logic                core_wreq;
    logic                core_bad_op;
    logic [XLEN-1:0]     zimm_ext;
    logic                core_win;
    logic                dbg_win;
    logic                calc_illegal;
    logic [XLEN-1:0]     new_val;

    assign zimm_ext = {{(XLEN-5){1'b0}}, bus.core_zimm_i};

    always_comb begin
        core_kind   = K_RW;
        core_src    = bus.core_wdata_i;
        core_wreq   = 1'b0;
        core_bad_op = 1'b0;
        case (bus.core_op_i)
            CSR_OP_WIDTH'(1): core_wreq = 1'b1;
            CSR_OP_WIDTH'(2): begin core_kind = K_RS; core_wreq = !bus.core_rs1_x0_i; end
            CSR_OP_WIDTH'(3): begin core_kind = K_RC; core_wreq = !bus.core_rs1_x0_i; end
            CSR_OP_WIDTH'(4): begin core_src = zimm_ext; core_wreq = 1'b1; end
            CSR_OP_WIDTH'(5): begin core_kind = K_RS; core_src = zimm_ext; core_wreq = |bus.core_zimm_i; end
            CSR_OP_WIDTH'(6): begin core_kind = K_RC; core_src = zimm_ext; core_wreq = |bus.core_zimm_i; end
            default:          core_bad_op = 1'b1;
        endcase
    end

    // Two-way round robin: last_dbg_q resets high so the core wins a reset-time tie.
    assign core_win = bus.core_req_i && (!bus.dbg_req_i || last_dbg_q);
    assign dbg_win  = bus.dbg_req_i && !core_win;

    assign calc_illegal = bus.csr_illegal_i || (wreq_q && (addr_q[CSR_ADDR-1 -: 2] == 2'b11));

    always_comb begin
        case (kind_q)
            K_RS:    new_val = bus.csr_rdata_i | src_q;
            K_RC:    new_val = bus.csr_rdata_i & ~src_q;
            default: new_val = src_q;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        kind_d         = kind_q;
        last_dbg_d     = last_dbg_q;
        src_dbg_d      = src_dbg_q;
        wreq_d         = wreq_q;
        illegal_d      = illegal_q;
        addr_d         = addr_q;
        src_d          = src_q;
        old_d          = old_q;
        core_ack_d     = 1'b0;
        core_rdata_d   = '0;
        core_illegal_d = 1'b0;
        dbg_ack_d      = 1'b0;
        dbg_rdata_d    = '0;
        dbg_err_d      = 1'b0;
        csr_addr_d     = csr_addr_q;
        csr_re_d       = 1'b0;
        csr_we_d       = 1'b0;
        csr_wdata_d    = '0;

        // Outputs are registered, so each is set on the transition into the state that shows it.
        case (state_q)
            S_IDLE: begin
                if (core_win) begin
                    src_dbg_d  = 1'b0;
                    last_dbg_d = 1'b0;
                    addr_d     = bus.core_addr_i;
                    kind_d     = core_kind;
                    src_d      = core_src;
                    wreq_d     = core_wreq;
                    if (core_bad_op) begin
                        state_d        = S_RESP;
                        core_ack_d     = 1'b1;
                        core_illegal_d = 1'b1;
                    end else begin
                        state_d    = S_READ;
                        csr_re_d   = 1'b1;
                        csr_addr_d = bus.core_addr_i;
                    end
                end else if (dbg_win) begin
                    src_dbg_d  = 1'b1;
                    last_dbg_d = 1'b1;
                    addr_d     = bus.dbg_addr_i;
                    kind_d     = K_RW;
                    src_d      = bus.dbg_wdata_i;
                    wreq_d     = bus.dbg_we_i;
                    state_d    = S_READ;
                    csr_re_d   = 1'b1;
                    csr_addr_d = bus.dbg_addr_i;
                end
            end
            S_READ: state_d = S_CALC;
            S_CALC: begin
                old_d       = bus.csr_rdata_i;
                illegal_d   = calc_illegal;
                csr_we_d    = wreq_q && !calc_illegal;
                csr_wdata_d = (wreq_q && !calc_illegal) ? new_val : '0;
                state_d     = S_WRITE;
            end
            S_WRITE: begin
                state_d = S_RESP;
                if (src_dbg_q) begin
                    dbg_ack_d   = 1'b1;
                    dbg_err_d   = illegal_q;
                    dbg_rdata_d = illegal_q ? '0 : old_q;
                end else begin
                    core_ack_d     = 1'b1;
                    core_illegal_d = illegal_q;
                    core_rdata_d   = illegal_q ? '0 : old_q;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            kind_q         <= K_RW;
            last_dbg_q     <= 1'b1;
            src_dbg_q      <= 1'b0;
            wreq_q         <= 1'b0;
            illegal_q      <= 1'b0;
            addr_q         <= '0;
            src_q          <= '0;
            old_q          <= '0;
            core_ack_q     <= 1'b0;
            core_rdata_q   <= '0;
            core_illegal_q <= 1'b0;
            dbg_ack_q      <= 1'b0;
            dbg_rdata_q    <= '0;
            dbg_err_q      <= 1'b0;
            csr_addr_q     <= '0;
            csr_re_q       <= 1'b0;
            csr_we_q       <= 1'b0;
            csr_wdata_q    <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            kind_q         <= kind_d;
            last_dbg_q     <= last_dbg_d;
            src_dbg_q      <= src_dbg_d;
            wreq_q         <= wreq_d;
            illegal_q      <= illegal_d;
            addr_q         <= addr_d;
            src_q          <= src_d;
            old_q          <= old_d;
            core_ack_q     <= core_ack_d;
            core_rdata_q   <= core_rdata_d;
            core_illegal_q <= core_illegal_d;
            dbg_ack_q      <= dbg_ack_d;
            dbg_rdata_q    <= dbg_rdata_d;
            dbg_err_q      <= dbg_err_d;
            csr_addr_q     <= csr_addr_d;
            csr_re_q       <= csr_re_d;
            csr_we_q       <= csr_we_d;
            csr_wdata_q    <= csr_wdata_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.core_ack_o     = core_ack_q;
    assign bus.core_rdata_o   = core_rdata_q;
    assign bus.core_illegal_o = core_illegal_q;
    assign bus.dbg_ack_o      = dbg_ack_q;
    assign bus.dbg_rdata_o    = dbg_rdata_q;
    assign bus.dbg_err_o      = dbg_err_q;
    assign bus.csr_addr_o     = csr_addr_q;
    assign bus.csr_re_o       = csr_re_q;
    assign bus.csr_we_o       = csr_we_q;
    assign bus.csr_wdata_o    = csr_wdata_q;
    assign bus.busy_o         = busy_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl with a behavioural CSR file model.
module tb_csr_access_ctrl;

    localparam logic [11:0] ILL_ADDR = 12'h7FF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   we_cnt = 0;

    logic        pre_en = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [31:0] pre_val = '0;
    logic [31:0] mem [0:4095];

    always #5 clk = ~clk;

    csr_access_ctrl_if #(.CSR_ADDR(12), .CSR_OP_WIDTH(3), .XLEN(32)) bus ();

    csr_access_ctrl #(.CSR_ADDR(12), .CSR_OP_WIDTH(3), .XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // CSR file: read data one cycle after the strobe, writes on the strobe edge.
    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_val;
        if (bus.csr_we_o) begin
            mem[bus.csr_addr_o] <= bus.csr_wdata_o;
            we_cnt <= we_cnt + 1;
        end
        if (bus.csr_re_o) begin
            bus.csr_rdata_i   <= mem[bus.csr_addr_o];
            bus.csr_illegal_i <= (bus.csr_addr_o == ILL_ADDR);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] v);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = a; pre_val = v;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".flags"}, 32'({bus.core_ack_o, bus.core_illegal_o, bus.dbg_ack_o, bus.dbg_err_o,
                                    bus.csr_re_o, bus.csr_we_o, bus.busy_o}), 32'd0);
        check({tag, ".data"}, bus.core_rdata_o | bus.dbg_rdata_o | bus.csr_wdata_o, 32'd0);
        check({tag, ".addr"}, 32'(bus.csr_addr_o), 32'd0);
    endtask

    task automatic core_txn(input string tag, input logic [2:0] op, input logic [11:0] a,
                            input logic [31:0] wd, input logic [4:0] zimm, input logic x0,
                            input logic exp_we, input logic [31:0] exp_wd,
                            input logic [31:0] exp_rd, input logic exp_ill);
        int we0;
        @(negedge clk);
        bus.core_req_i = 1'b1; bus.core_op_i = op; bus.core_addr_i = a;
        bus.core_wdata_i = wd; bus.core_zimm_i = zimm; bus.core_rs1_x0_i = x0;
        we0 = we_cnt;
        @(negedge clk);
        if (op == 3'd0 || op == 3'd7) begin
            check({tag, ".ack1"}, 32'(bus.core_ack_o), 32'd1);
            check({tag, ".ill"}, 32'(bus.core_illegal_o), 32'(exp_ill));
            check({tag, ".rd"}, bus.core_rdata_o, exp_rd);
            check({tag, ".no_re"}, 32'(bus.csr_re_o), 32'd0);
        end else begin
            check({tag, ".re1"}, 32'({bus.csr_re_o, bus.busy_o, bus.core_ack_o}), 32'b110);
            check({tag, ".addr"}, 32'(bus.csr_addr_o), 32'(a));
            @(negedge clk);
            @(negedge clk);
            check({tag, ".we3"}, 32'(bus.csr_we_o), 32'(exp_we));
            if (exp_we) check({tag, ".wd"}, bus.csr_wdata_o, exp_wd);
            @(negedge clk);
            check({tag, ".ack4"}, 32'({bus.core_ack_o, bus.dbg_ack_o}), 32'b10);
            check({tag, ".rd"}, bus.core_rdata_o, exp_rd);
            check({tag, ".ill"}, 32'(bus.core_illegal_o), 32'(exp_ill));
        end
        bus.core_req_i = 1'b0;
        @(negedge clk);
        check({tag, ".idle"}, 32'({bus.busy_o, bus.core_ack_o}), 32'd0);
        check({tag, ".wecnt"}, 32'(we_cnt - we0), 32'(exp_we));
    endtask

    task automatic dbg_txn(input string tag, input logic we, input logic [11:0] a,
                           input logic [31:0] wd, input logic exp_we, input logic [31:0] exp_wd,
                           input logic [31:0] exp_rd, input logic exp_err);
        int we0;
        @(negedge clk);
        bus.dbg_req_i = 1'b1; bus.dbg_we_i = we; bus.dbg_addr_i = a; bus.dbg_wdata_i = wd;
        we0 = we_cnt;
        @(negedge clk);
        check({tag, ".re1"}, 32'(bus.csr_re_o), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check({tag, ".we3"}, 32'(bus.csr_we_o), 32'(exp_we));
        if (exp_we) check({tag, ".wd"}, bus.csr_wdata_o, exp_wd);
        @(negedge clk);
        check({tag, ".ack4"}, 32'({bus.dbg_ack_o, bus.core_ack_o}), 32'b10);
        check({tag, ".rd"}, bus.dbg_rdata_o, exp_rd);
        check({tag, ".err"}, 32'(bus.dbg_err_o), 32'(exp_err));
        bus.dbg_req_i = 1'b0;
        @(negedge clk);
        check({tag, ".wecnt"}, 32'(we_cnt - we0), 32'(exp_we));
    endtask

    initial begin
        int waited;
        bus.core_req_i = 1'b0; bus.core_addr_i = '0; bus.core_op_i = '0; bus.core_wdata_i = '0;
        bus.core_zimm_i = '0; bus.core_rs1_x0_i = 1'b0;
        bus.dbg_req_i = 1'b0; bus.dbg_addr_i = '0; bus.dbg_we_i = 1'b0; bus.dbg_wdata_i = '0;

        repeat (2) @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;

        // Simultaneous requests after reset: core first, then debug beats a core re-request.
        preload(12'h300, 32'h11);
        preload(12'h301, 32'h22);
        @(negedge clk);
        bus.core_req_i = 1'b1; bus.core_op_i = 3'd2; bus.core_addr_i = 12'h300; bus.core_rs1_x0_i = 1'b1;
        bus.dbg_req_i = 1'b1; bus.dbg_we_i = 1'b0; bus.dbg_addr_i = 12'h301;
        @(negedge clk);
        check("arb.first_addr", 32'(bus.csr_addr_o), 32'h300);
        repeat (3) @(negedge clk);
        check("arb.core_ack", 32'({bus.core_ack_o, bus.dbg_ack_o}), 32'b10);
        check("arb.core_rd", bus.core_rdata_o, 32'h11);
        bus.core_req_i = 1'b0;
        @(negedge clk);
        bus.core_req_i = 1'b1;
        @(negedge clk);
        check("arb.second_addr", 32'(bus.csr_addr_o), 32'h301);
        repeat (3) @(negedge clk);
        check("arb.dbg_ack", 32'({bus.dbg_ack_o, bus.core_ack_o}), 32'b10);
        check("arb.dbg_rd", bus.dbg_rdata_o, 32'h22);
        bus.dbg_req_i = 1'b0;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.core_ack_o && waited < 10);
        check("arb.core_again_ack", 32'(bus.core_ack_o), 32'd1);
        check("arb.core_again_lat", 32'(waited), 32'd5);
        check("arb.core_again_rd", bus.core_rdata_o, 32'h11);
        bus.core_req_i = 1'b0;
        @(negedge clk);

        preload(12'h340, 32'h12345678);
        core_txn("rw", 3'd1, 12'h340, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h12345678, 1'b0);

        preload(12'hC00, 32'h42);
        core_txn("rs_x0_ro", 3'd2, 12'hC00, 32'hFFFF, 5'd0, 1'b1, 1'b0, 32'h0, 32'h42, 1'b0);
        core_txn("rw_ro", 3'd1, 12'hC00, 32'h1, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        preload(12'h341, 32'hFF);
        core_txn("rci", 3'd6, 12'h341, 32'h0, 5'd5, 1'b0, 1'b1, 32'hFA, 32'hFF, 1'b0);
        core_txn("rsi0", 3'd5, 12'h341, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0, 32'h0, 32'hFA, 1'b0);
        core_txn("rc", 3'd3, 12'h341, 32'hF0, 5'd0, 1'b0, 1'b1, 32'h0A, 32'hFA, 1'b0);
        core_txn("rs", 3'd2, 12'h341, 32'h100, 5'd0, 1'b0, 1'b1, 32'h10A, 32'h0A, 1'b0);
        core_txn("rwi", 3'd4, 12'h341, 32'hFFFF_FFFF, 5'd31, 1'b0, 1'b1, 32'h1F, 32'h10A, 1'b0);
        core_txn("rc_x0", 3'd3, 12'h341, 32'hFFFF_FFFF, 5'd0, 1'b1, 1'b0, 32'h0, 32'h1F, 1'b0);

        core_txn("op7", 3'd7, 12'h341, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        core_txn("op0", 3'd0, 12'h341, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        preload(ILL_ADDR, 32'h55);
        dbg_txn("dbg_ill", 1'b0, ILL_ADDR, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        core_txn("core_ill", 3'd2, ILL_ADDR, 32'h0, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
        preload(12'h342, 32'h1);
        dbg_txn("dbg_wr", 1'b1, 12'h342, 32'hCAFE0000, 1'b1, 32'hCAFE0000, 32'h1, 1'b0);
        dbg_txn("dbg_rd", 1'b0, 12'h342, 32'h0, 1'b0, 32'h0, 32'hCAFE0000, 1'b0);
        dbg_txn("dbg_wr_ro", 1'b1, 12'hC00, 32'h9, 1'b0, 32'h0, 32'h0, 1'b1);

        // Reset lands just after the edge that enters WRITE; the file never sees a write edge.
        preload(12'h343, 32'h77);
        @(negedge clk);
        bus.core_req_i = 1'b1; bus.core_op_i = 3'd1; bus.core_addr_i = 12'h343; bus.core_wdata_i = 32'h99;
        waited = we_cnt;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.core_req_i = 1'b0;
        @(negedge clk);
        check_quiet("midrst");
        repeat (2) @(negedge clk);
        check("midrst.no_write", 32'(we_cnt - waited), 32'd0);
        rst_n = 1'b1;
        core_txn("post_rst_rd", 3'd2, 12'h343, 32'h0, 5'd0, 1'b1, 1'b0, 32'h0, 32'h77, 1'b0);
        core_txn("post_rst_rw", 3'd1, 12'h343, 32'h99, 5'd0, 1'b0, 1'b1, 32'h99, 32'h77, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
